issue_ctrl: RTL

- Issue/hazard controller between instr_dec outputs and the execute stage.
- Holds a per-register, per-half scoreboard of pending writebacks and stalls decode/PC on RAW and WAW hazards.
- Bounds the number of in-flight writes.
- Sequences HALT: stops issue, drains outstanding writebacks, then parks in a halted state until resumed.

---
 rtl/issue_ctrl_pkg.sv | 24 ++
 rtl/issue_ctrl_scoreboard.sv | 91 +++++++++
 rtl/issue_ctrl.sv | 99 +++++++++
 3 files changed

// File: rtl/issue_ctrl_pkg.sv
// Shared definitions for the issue controller: opcode constants, write-scope
// encodings and the issue FSM state type.
package issue_ctrl_pkg;

  localparam logic [5:0] OPCODE_NOP   = 6'h00;
  localparam logic [5:0] OPCODE_ADDU  = 6'h01;
  localparam logic [5:0] OPCODE_ADDUI = 6'h02;
  localparam logic [5:0] OPCODE_MOVIL = 6'h03;
  localparam logic [5:0] OPCODE_MOVIH = 6'h04;
  localparam logic [5:0] OPCODE_ST    = 6'h05;
  localparam logic [5:0] OPCODE_HALT  = 6'h3F;

  localparam logic [1:0] SCOPE_NONE = 2'b00;
  localparam logic [1:0] SCOPE_LO   = 2'b01;
  localparam logic [1:0] SCOPE_HI   = 2'b10;
  localparam logic [1:0] SCOPE_WORD = 2'b11;

  typedef enum logic [1:0] {
    ISSUE_RUN    = 2'd0,
    ISSUE_DRAIN  = 2'd1,
    ISSUE_HALTED = 2'd2
  } issue_state_e;

endpackage

// File: rtl/issue_ctrl_scoreboard.sv
// Per-register, per-half pending-write scoreboard with an in-flight write
// counter and a sticky error flag for writebacks that match nothing pending.
module issue_ctrl_scoreboard
  import issue_ctrl_pkg::*;
#(
  parameter int NREG         = 16,
  parameter int RI_W         = 4,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [RI_W-1:0]   op1_ri,
  input  logic [RI_W-1:0]   op2_ri,
  input  logic [RI_W-1:0]   wr_ri,
  output logic [1:0]        op1_busy,
  output logic [1:0]        op2_busy,
  output logic [1:0]        wr_busy,
  input  logic              set_valid,
  input  logic [RI_W-1:0]   set_ri,
  input  logic [1:0]        set_scope,
  input  logic              clr_valid,
  input  logic [RI_W-1:0]   clr_ri,
  input  logic [1:0]        clr_scope,
  output logic [2*NREG-1:0] busy_mask,
  output logic [3:0]        inflight,
  output logic              full,
  output logic              empty,
  output logic              wb_err
);

  logic [2*NREG-1:0] busy_q, busy_d;
  logic [3:0]        inflight_q, inflight_d;
  logic              wb_err_q, wb_err_d;
  logic              set_en, clr_en, bad_wb;

  function automatic logic [1:0] halves(input logic [2*NREG-1:0] mask,
                                        input logic [RI_W-1:0]   ri);
    halves = 2'b00;
    for (int r = 0; r < NREG; r++)
      if (ri == RI_W'(r)) halves = mask[2*r +: 2];
  endfunction

  function automatic logic [2*NREG-1:0] place(input logic [RI_W-1:0] ri,
                                              input logic [1:0]      scope);
    place = '0;
    for (int r = 0; r < NREG; r++)
      if (ri == RI_W'(r)) place[2*r +: 2] = scope;
  endfunction

  always_comb begin
    op1_busy = halves(busy_q, op1_ri);
    op2_busy = halves(busy_q, op2_ri);
    wr_busy  = halves(busy_q, wr_ri);
  end

  // Clear before set, so a same-cycle issue to a retiring half leaves it busy.
  always_comb begin
    set_en   = set_valid && (set_scope != SCOPE_NONE);
    clr_en   = clr_valid && (clr_scope != SCOPE_NONE);
    busy_d   = busy_q;
    if (clr_en) busy_d = busy_d & ~place(clr_ri, clr_scope);
    if (set_en) busy_d = busy_d | place(set_ri, set_scope);
    bad_wb   = clr_en && (((halves(busy_q, clr_ri) & clr_scope) != clr_scope) ||
                          (inflight_q == 4'd0));
    wb_err_d = wb_err_q | bad_wb;
    inflight_d = inflight_q;
    if (set_en && !clr_en)
      inflight_d = inflight_q + 4'd1;
    else if (clr_en && !set_en && (inflight_q != 4'd0))
      inflight_d = inflight_q - 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q     <= '0;
      inflight_q <= 4'd0;
      wb_err_q   <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      inflight_q <= inflight_d;
      wb_err_q   <= wb_err_d;
    end
  end

  assign busy_mask = busy_q;
  assign inflight  = inflight_q;
  assign wb_err    = wb_err_q;
  assign full      = (inflight_q == 4'(MAX_INFLIGHT));
  assign empty     = (inflight_q == 4'd0) && (busy_q == '0);

endmodule

// File: rtl/issue_ctrl.sv
// Issue/hazard controller between decode and execute: stalls on RAW, WAW and
// in-flight limit, and sequences HALT through a drain into a parked state.
module issue_ctrl
  import issue_ctrl_pkg::*;
#(
  parameter int NREG         = 16,
  parameter int RI_W         = 4,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dec_valid,
  output logic              dec_ready,
  input  logic [5:0]        dec_opcode,
  input  logic [RI_W-1:0]   dec_op1_ri,
  input  logic              dec_re1,
  input  logic [RI_W-1:0]   dec_op2_ri,
  input  logic              dec_re2,
  input  logic [RI_W-1:0]   dec_wr_ri,
  input  logic [1:0]        dec_wr_scope,
  input  logic              dec_wre,
  input  logic              dec_pc_halt,
  output logic              exe_valid,
  input  logic              exe_ready,
  input  logic              wb_valid,
  input  logic [RI_W-1:0]   wb_ri,
  input  logic [1:0]        wb_scope,
  input  logic              resume,
  output logic              pc_stall,
  output logic              halted,
  output logic [3:0]        inflight,
  output logic [2*NREG-1:0] busy_mask,
  output logic              wb_err
);

  issue_state_e state_q, state_d;
  logic [1:0]   op1_busy, op2_busy, wr_busy;
  logic         sb_full, sb_empty;
  logic         hazard, can_issue, issue;
  // The opcode travels to execute on its own path; HALT is flagged by dec_pc_halt.
  logic         unused_opcode;

  assign unused_opcode = ^dec_opcode;

  issue_ctrl_scoreboard #(
    .NREG(NREG), .RI_W(RI_W), .MAX_INFLIGHT(MAX_INFLIGHT)
  ) u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .op1_ri    (dec_op1_ri),
    .op2_ri    (dec_op2_ri),
    .wr_ri     (dec_wr_ri),
    .op1_busy  (op1_busy),
    .op2_busy  (op2_busy),
    .wr_busy   (wr_busy),
    .set_valid (issue && dec_wre),
    .set_ri    (dec_wr_ri),
    .set_scope (dec_wr_scope),
    .clr_valid (wb_valid),
    .clr_ri    (wb_ri),
    .clr_scope (wb_scope),
    .busy_mask (busy_mask),
    .inflight  (inflight),
    .full      (sb_full),
    .empty     (sb_empty),
    .wb_err    (wb_err)
  );

  // Hazards look only at registered scoreboard state; no writeback bypass.
  always_comb begin
    hazard    = (dec_re1 && (op1_busy != 2'b00)) ||
                (dec_re2 && (op2_busy != 2'b00)) ||
                (dec_wre && ((wr_busy & dec_wr_scope) != 2'b00)) ||
                (dec_wre && sb_full);
    can_issue = (state_q == ISSUE_RUN) && dec_valid && !hazard;
  end

  assign exe_valid = can_issue;
  assign dec_ready = can_issue && exe_ready;
  assign issue     = dec_ready;
  assign pc_stall  = (dec_valid && !dec_ready) || (state_q != ISSUE_RUN);
  assign halted    = (state_q == ISSUE_HALTED);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ISSUE_RUN:    if (issue && dec_pc_halt) state_d = ISSUE_DRAIN;
      ISSUE_DRAIN:  if (sb_empty)             state_d = ISSUE_HALTED;
      ISSUE_HALTED: if (resume)               state_d = ISSUE_RUN;
      default:                                state_d = ISSUE_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ISSUE_RUN;
    else        state_q <= state_d;
  end

endmodule
